// File: rtl/aplic_cfg_pkg.sv
// Shared types and address decode for the APLIC config-bus bridge.
package aplic_cfg_pkg;

    localparam int unsigned DEC_ADDR_W = 64;
    localparam int unsigned DEC_IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ERR,
        RESP
    } state_e;

    typedef struct packed {
        logic                  hit;
        logic [DEC_IDX_W-1:0]  idx;
        logic [DEC_ADDR_W-1:0] offset;
    } dom_dec_t;

    // Inputs are zero-extended ADDR_W values, so addr < base is exactly the ADDR_W-bit borrow.
    function automatic dom_dec_t dom_decode(
        input logic [DEC_ADDR_W-1:0] addr,
        input logic [DEC_ADDR_W-1:0] base,
        input int unsigned           stride_lg,
        input int unsigned           nr_domains
    );
        logic [DEC_ADDR_W-1:0] diff;
        logic [DEC_ADDR_W-1:0] mask;
        logic [DEC_ADDR_W-1:0] idx_full;
        dom_dec_t              res;
        diff       = addr - base;
        mask       = (DEC_ADDR_W'(1) << stride_lg) - DEC_ADDR_W'(1);
        idx_full   = diff >> stride_lg;
        res.hit    = (addr >= base) && (idx_full < DEC_ADDR_W'(nr_domains));
        res.idx    = DEC_IDX_W'(idx_full);
        res.offset = diff & mask;
        return res;
    endfunction

endpackage

// File: rtl/aplic_cfg_timeout.sv
// Saturating ISSUE-cycle counter; expired_c flags the last allowed cycle. TIMEOUT=0 never expires.
module aplic_cfg_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned LAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_c = ENABLED && en && (cnt_q == CW'(LAST));

endmodule

// File: rtl/aplic_cfg_bridge.sv
// Config-bus bridge: one upstream reg-interface master to NR_DOMAINS APLIC domain slaves,
// one outstanding request, error response for unmapped addresses and hung slaves.
module aplic_cfg_bridge
    import aplic_cfg_pkg::*;
#(
    parameter int unsigned       NR_DOMAINS    = 2,
    parameter int unsigned       ADDR_W        = 32,
    parameter int unsigned       DATA_W        = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(32'h0C00_0000),
    parameter logic [ADDR_W-1:0] DOMAIN_STRIDE = ADDR_W'(32'h0000_8000),
    parameter int unsigned       TIMEOUT       = 255
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [ADDR_W-1:0]                   i_req_addr,
    input  logic                                i_req_write,
    input  logic [DATA_W-1:0]                   i_req_wdata,
    input  logic [DATA_W/8-1:0]                 i_req_wstrb,
    input  logic                                i_req_valid,
    output logic [DATA_W-1:0]                   o_resp_rdata,
    output logic                                o_resp_error,
    output logic                                o_resp_ready,
    output logic [NR_DOMAINS-1:0][ADDR_W-1:0]   o_dom_addr,
    output logic [NR_DOMAINS-1:0]               o_dom_write,
    output logic [NR_DOMAINS-1:0][DATA_W-1:0]   o_dom_wdata,
    output logic [NR_DOMAINS-1:0][DATA_W/8-1:0] o_dom_wstrb,
    output logic [NR_DOMAINS-1:0]               o_dom_valid,
    input  logic [NR_DOMAINS-1:0][DATA_W-1:0]   i_dom_rdata,
    input  logic [NR_DOMAINS-1:0]               i_dom_error,
    input  logic [NR_DOMAINS-1:0]               i_dom_ready,
    output logic                                o_busy
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned IDX_W     = (NR_DOMAINS > 1) ? $clog2(NR_DOMAINS) : 1;
    localparam int unsigned STRIDE_LG = $clog2(DOMAIN_STRIDE);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]     off_q;
    logic                  write_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  resp_ready_q;
    logic [NR_DOMAINS-1:0] dom_valid_q;
    logic                  busy_q;
    logic                  cap_en;
    logic                  resp_load;
    logic                  expired;
    dom_dec_t              dec;
    logic                  unused_dec;

    assign dec = dom_decode(DEC_ADDR_W'(i_req_addr), DEC_ADDR_W'(BASE_ADDR),
                            STRIDE_LG, NR_DOMAINS);
    // Only the low ADDR_W offset bits and IDX_W index bits matter downstream.
    assign unused_dec = ^dec;

    aplic_cfg_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (i_clk),
        .rst       (i_rst),
        .clr       (state_q != ISSUE),
        .en        (state_q == ISSUE),
        .expired_c (expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus capture/response load strobes; a ready slave beats a coincident timeout.
    always_comb begin
        state_d   = state_q;
        cap_en    = 1'b0;
        idx_d     = idx_q;
        resp_load = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    cap_en  = 1'b1;
                    idx_d   = IDX_W'(dec.idx);
                    state_d = dec.hit ? ISSUE : ERR;
                end
            end
            ISSUE: begin
                if (i_dom_ready[idx_q]) begin
                    state_d   = RESP;
                    resp_load = 1'b1;
                    rdata_d   = write_q ? '0 : i_dom_rdata[idx_q];
                    err_d     = i_dom_error[idx_q];
                end else if (expired) begin
                    state_d   = RESP;
                    resp_load = 1'b1;
                    err_d     = 1'b1;
                end
            end
            ERR: begin
                state_d   = RESP;
                resp_load = 1'b1;
                err_d     = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, latched response and registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            off_q        <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            idx_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_ready_q <= 1'b0;
            dom_valid_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            if (cap_en) begin
                off_q   <= ADDR_W'(dec.offset);
                write_q <= i_req_write;
                wdata_q <= i_req_wdata;
                wstrb_q <= i_req_wstrb;
                idx_q   <= idx_d;
            end
            if (resp_load) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
            resp_ready_q <= (state_d == RESP);
            dom_valid_q  <= (state_d == ISSUE) ? (NR_DOMAINS'(1) << idx_d) : '0;
            busy_q       <= (state_d != IDLE);
        end
    end

    // Request fields are broadcast; only the one-hot valid selects the slave.
    for (genvar d = 0; d < NR_DOMAINS; d++) begin : g_dom
        assign o_dom_addr[d]  = off_q;
        assign o_dom_write[d] = write_q;
        assign o_dom_wdata[d] = wdata_q;
        assign o_dom_wstrb[d] = wstrb_q;
    end

    assign o_dom_valid  = dom_valid_q;
    assign o_resp_ready = resp_ready_q;
    assign o_resp_rdata = rdata_q;
    assign o_resp_error = err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_aplic_cfg_bridge.sv
// Directed self-checking bench for aplic_cfg_bridge (NR_DOMAINS=2, TIMEOUT=8).
module tb_aplic_cfg_bridge;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       req_addr;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              req_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic              resp_ready;
    logic [1:0][31:0]  dom_addr;
    logic [1:0]        dom_write;
    logic [1:0][31:0]  dom_wdata;
    logic [1:0][3:0]   dom_wstrb;
    logic [1:0]        dom_valid;
    logic [1:0][31:0]  dom_rdata;
    logic [1:0]        dom_error;
    logic [1:0]        dom_ready;
    logic              busy;

    int errors = 0;
    int checks = 0;

    aplic_cfg_bridge #(
        .NR_DOMAINS (2),
        .TIMEOUT    (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_addr   (req_addr),
        .i_req_write  (req_write),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .i_req_valid  (req_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_error (resp_error),
        .o_resp_ready (resp_ready),
        .o_dom_addr   (dom_addr),
        .o_dom_write  (dom_write),
        .o_dom_wdata  (dom_wdata),
        .o_dom_wstrb  (dom_wstrb),
        .o_dom_valid  (dom_valid),
        .i_dom_rdata  (dom_rdata),
        .i_dom_error  (dom_error),
        .i_dom_ready  (dom_ready),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] ws);
        req_addr  = a;
        req_write = w;
        req_wdata = wd;
        req_wstrb = ws;
        req_valid = 1'b1;
    endtask

    task automatic idle_bus();
        req_valid = 1'b0;
        dom_ready = 2'b00;
        dom_error = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        req_valid = 1'b0;
        dom_rdata = '0;
        dom_error = '0;
        dom_ready = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_ready", 64'(resp_ready), 64'd0);
        chk("rst_dom_valid", 64'(dom_valid), 64'd0);
        chk("rst_dom_addr", 64'(dom_addr), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        rst = 1'b0;
        tick();

        // 1: read in domain 1, slave ready in the first ISSUE cycle
        request(32'h0C00_8004, 1'b0, 32'h0, 4'h0);
        tick();
        chk("t1_dom_valid", 64'(dom_valid), 64'h2);
        chk("t1_dom_addr", 64'(dom_addr[1]), 64'h4);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_no_early_resp", 64'(resp_ready), 64'd0);
        dom_ready = 2'b11;
        dom_rdata = {32'h0000_1234, 32'hDEAD_BEEF};
        dom_error = 2'b01;
        tick();
        chk("t1_resp_ready", 64'(resp_ready), 64'd1);
        chk("t1_rdata", 64'(resp_rdata), 64'h1234);
        chk("t1_error", 64'(resp_error), 64'd0);
        chk("t1_valid_drop", 64'(dom_valid), 64'd0);
        idle_bus();
        tick();
        chk("t1_resp_one_cycle", 64'(resp_ready), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: write in domain 0; upstream change after capture must be ignored
        request(32'h0C00_0010, 1'b1, 32'hA5A5_A5A5, 4'h3);
        tick();
        chk("t2_dom_valid", 64'(dom_valid), 64'h1);
        chk("t2_dom_addr", 64'(dom_addr[0]), 64'h10);
        chk("t2_dom_write", 64'(dom_write[0]), 64'd1);
        chk("t2_dom_wdata", 64'(dom_wdata[0]), 64'hA5A5_A5A5);
        chk("t2_dom_wstrb", 64'(dom_wstrb[0]), 64'h3);
        req_wdata = 32'h0;
        req_addr  = 32'h0C00_8000;
        dom_ready = 2'b01;
        dom_rdata = {32'h1111_1111, 32'hFFFF_FFFF};
        tick();
        chk("t2_resp_ready", 64'(resp_ready), 64'd1);
        chk("t2_error", 64'(resp_error), 64'd0);
        chk("t2_rdata_zero", 64'(resp_rdata), 64'd0);
        chk("t2_wdata_held", 64'(dom_wdata[0]), 64'hA5A5_A5A5);
        idle_bus();
        tick();

        // 3a: index 2 is past the last domain
        request(32'h0C01_0000, 1'b0, 32'h0, 4'h0);
        tick();
        chk("t3a_no_valid", 64'(dom_valid), 64'd0);
        chk("t3a_busy", 64'(busy), 64'd1);
        dom_ready = 2'b11;
        dom_rdata = {32'h7777_7777, 32'h8888_8888};
        tick();
        chk("t3a_resp_ready", 64'(resp_ready), 64'd1);
        chk("t3a_error", 64'(resp_error), 64'd1);
        chk("t3a_rdata", 64'(resp_rdata), 64'd0);
        idle_bus();
        tick();

        // 3b: below the base address
        request(32'h0B00_0000, 1'b0, 32'h0, 4'h0);
        tick();
        chk("t3b_no_valid", 64'(dom_valid), 64'd0);
        tick();
        chk("t3b_resp_ready", 64'(resp_ready), 64'd1);
        chk("t3b_error", 64'(resp_error), 64'd1);
        chk("t3b_rdata", 64'(resp_rdata), 64'd0);
        idle_bus();
        tick();

        // 4: domain 0 never answers; 8 ISSUE cycles then error response
        request(32'h0C00_0000, 1'b0, 32'h0, 4'h0);
        dom_rdata = {32'h0, 32'h9999_9999};
        tick();
        n = 0;
        while (dom_valid == 2'b01 && n < 20) begin
            n++;
            tick();
        end
        chk("t4_issue_cycles", 64'(n), 64'd8);
        chk("t4_resp_ready", 64'(resp_ready), 64'd1);
        chk("t4_error", 64'(resp_error), 64'd1);
        chk("t4_rdata", 64'(resp_rdata), 64'd0);
        idle_bus();
        tick();
        request(32'h0C00_0008, 1'b0, 32'h0, 4'h0);
        tick();
        chk("t4_next_addr", 64'(dom_addr[0]), 64'h8);
        dom_ready = 2'b01;
        dom_error = 2'b01;
        dom_rdata = {32'h0, 32'h0000_0055};
        tick();
        chk("t4_next_ready", 64'(resp_ready), 64'd1);
        chk("t4_next_rdata", 64'(resp_rdata), 64'h55);
        chk("t4_next_slave_err", 64'(resp_error), 64'd1);
        idle_bus();
        tick();

        // 5: reset in the middle of ISSUE, then a request at the top of domain 1
        request(32'h0C00_8000, 1'b0, 32'h0, 4'h0);
        tick();
        chk("t5_pre_valid", 64'(dom_valid), 64'h2);
        #2;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(dom_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        request(32'h0C00_FFFC, 1'b0, 32'h0, 4'h0);
        tick();
        chk("t5_valid", 64'(dom_valid), 64'h2);
        chk("t5_top_offset", 64'(dom_addr[1]), 64'h7FFC);
        dom_ready = 2'b10;
        dom_rdata = {32'h0000_CAFE, 32'h0};
        tick();
        chk("t5_resp_ready", 64'(resp_ready), 64'd1);
        chk("t5_rdata", 64'(resp_rdata), 64'hCAFE);
        chk("t5_error", 64'(resp_error), 64'd0);
        idle_bus();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
